// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential HI/LO multiply/divide unit.
// The DIV state exists only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = $clog2(MULDIV_ITER);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL
`ifdef MULDIV_DIV_EN
        , ST_DIV
`endif
    } state_t;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] x);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider datapath.
// The divide path and i_is_div exist only when MULDIV_DIV_EN is defined.
module muldiv_step (
`ifdef MULDIV_DIV_EN
    input  logic        i_is_div,
`endif
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
    logic [32:0] w_sum;
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : 33'd0);

`ifdef MULDIV_DIV_EN
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [32:0] w_rs;
    logic [31:0] w_diff;
    logic        w_ge;

    assign w_rs   = {i_hi, i_lo[31]};
    assign w_ge   = (w_rs >= {1'b0, i_b});
    assign w_diff = w_rs[31:0] - i_b;

    always_comb begin
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_rs[31:0];
            o_lo = {i_lo[30:0], w_ge};
        end else begin
            o_hi = w_sum[32:1];
            o_lo = {w_sum[0], i_lo[31:1]};
        end
    end
`else
    assign o_hi = w_sum[32:1];
    assign o_lo = {w_sum[0], i_lo[31:1]};
`endif

endmodule

// File: rtl/muldiv_seq.sv
// 32-cycle sequential MULT/MULTU (and DIV/DIVU with MULDIV_DIV_EN) writing HI/LO,
// with the stall request the hazard unit needs while a result is pending.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        StartE,
    input  logic [1:0]  OpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MulDivD,
    input  logic        MfHiLoD,
    output logic        MulDivStall,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Ready,
    output logic        DivZero
);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_start, w_signed, w_busy, w_last, w_accept;
    logic [31:0]      w_a_mag, w_b_mag;
    logic [31:0]      r_acc_hi, r_acc_lo, r_b, w_step_hi, w_step_lo;
    logic             r_neg;
    logic [31:0]      w_res_hi, w_res_lo;
    logic [31:0]      r_hi, r_lo;
    logic             r_ready;

    function automatic logic [63:0] neg64_if(input logic en, input logic [63:0] x);
        return en ? (~x + 64'd1) : x;
    endfunction

    function automatic logic [31:0] neg32_if(input logic en, input logic [31:0] x);
        return en ? (~x + 32'd1) : x;
    endfunction

`ifdef MULDIV_DIV_EN
    logic        w_start_div, r_div, r_neg_r, r_bzero, w_res_dz, r_divzero;
    logic [31:0] r_a_raw;
    assign w_start     = StartE;
    assign w_start_div = (OpE == OP_DIV) || (OpE == OP_DIVU);
    assign w_signed    = (OpE == OP_MULT) || (OpE == OP_DIV);
`else
    assign w_start  = StartE && ((OpE == OP_MULT) || (OpE == OP_MULTU));
    assign w_signed = (OpE == OP_MULT);
`endif

    assign w_a_mag  = mag32(w_signed, SrcAE);
    assign w_b_mag  = mag32(w_signed, SrcBE);
    assign w_last   = (r_state != ST_IDLE) && (r_cnt == CNT_W'(MULDIV_ITER - 1));
    assign w_accept = (r_state == ST_IDLE) && w_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef MULDIV_DIV_EN
                if (w_start) w_next = w_start_div ? ST_DIV : ST_MUL;
`else
                if (w_start) w_next = ST_MUL;
`endif
            end
            ST_MUL:  if (w_last) w_next = ST_IDLE;
`ifdef MULDIV_DIV_EN
            ST_DIV:  if (w_last) w_next = ST_IDLE;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE) || w_start;
        MulDivStall = w_busy && (MfHiLoD || MulDivD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_cnt <= '0;
        else if (r_state == ST_IDLE) r_cnt <= '0;
        else                        r_cnt <= r_cnt + CNT_W'(1);
    end

    // Working operands are latched at start so later SrcAE/SrcBE changes cannot leak in.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc_hi <= '0;
            r_neg    <= w_signed && (SrcAE[31] ^ SrcBE[31]);
`ifdef MULDIV_DIV_EN
            r_div    <= w_start_div;
            r_neg_r  <= w_signed && SrcAE[31];
            r_bzero  <= (SrcBE == 32'd0);
            r_a_raw  <= SrcAE;
            r_acc_lo <= w_start_div ? w_a_mag : w_b_mag;
            r_b      <= w_start_div ? w_b_mag : w_a_mag;
`else
            r_acc_lo <= w_b_mag;
            r_b      <= w_a_mag;
`endif
        end else if (r_state != ST_IDLE) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end
    end

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .i_is_div (r_div),
`endif
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_b      (r_b),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Sign fix-up applied to the final iteration's output, captured on the completion edge.
    always_comb begin
        {w_res_hi, w_res_lo} = neg64_if(r_neg, {w_step_hi, w_step_lo});
`ifdef MULDIV_DIV_EN
        w_res_dz = 1'b0;
        if (r_div) begin
            if (r_bzero) begin
                w_res_hi = r_a_raw;
                w_res_lo = 32'hFFFF_FFFF;
                w_res_dz = 1'b1;
            end else begin
                w_res_hi = neg32_if(r_neg_r, w_step_hi);
                w_res_lo = neg32_if(r_neg, w_step_lo);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_last;
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_divzero <= 1'b0;
        else     r_divzero <= w_last && w_res_dz;
    end
    assign DivZero = r_divzero;
`else
    assign DivZero = 1'b0;
`endif

    assign Hi    = r_hi;
    assign Lo    = r_lo;
    assign Ready = r_ready;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq; divide vectors apply when MULDIV_DIV_EN is defined,
// otherwise divide starts are expected to be ignored.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, StartE, MulDivD, MfHiLoD;
    logic [1:0]  OpE;
    logic [31:0] SrcAE, SrcBE;
    logic        MulDivStall, Ready, DivZero;
    logic [31:0] Hi, Lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .StartE      (StartE),
        .OpE         (OpE),
        .SrcAE       (SrcAE),
        .SrcBE       (SrcBE),
        .MulDivD     (MulDivD),
        .MfHiLoD     (MfHiLoD),
        .MulDivStall (MulDivStall),
        .Hi          (Hi),
        .Lo          (Lo),
        .Ready       (Ready),
        .DivZero     (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every Ready pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && Ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: Ready=1 Hi=%h Lo=%h, required Ready=0", Hi, Lo);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_hi", {32'd0, Hi}, {32'd0, mon_e.hi});
                check("sb_lo", {32'd0, Lo}, {32'd0, mon_e.lo});
                check("sb_divzero", {63'd0, DivZero}, {63'd0, mon_e.dz});
            end
        end else if (!rst && DivZero) begin
            checks++;
            errors++;
            $display("FAIL divzero_without_ready: DivZero=1 Ready=0, required DivZero=0");
        end
    end

    // Called just after a rising edge; returns in the Ready cycle so the next call is back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mf, input logic poke,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string nm);
        int   n;
        int   stall_n;
        logic seen;
        sb_q.push_back({eh, el, edz});
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; MfHiLoD = mf; MulDivD = 1'b0;
        #1;
        stall_n = MulDivStall ? 1 : 0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                StartE = 1'b0; SrcAE = ~a; SrcBE = ~b ^ 32'h5;
            end
            if (poke && n == 6) begin
                StartE = 1'b1; OpE = OP_MULTU; SrcAE = 32'h3; SrcBE = 32'h3;
            end
            if (poke && n == 7) StartE = 1'b0;
            #1;
            if (Ready) seen = 1'b1;
            else if (MulDivStall) stall_n++;
        end
        check({nm, "_latency"}, n, 33);
        if (mf) begin
            check({nm, "_stall_cycles"}, stall_n, 33);
            check({nm, "_stall_in_ready"}, {63'd0, MulDivStall}, 64'd0);
        end
    endtask

    initial begin
        int rdy_n;
        int stl_n;
        rst = 1'b1; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0;
        MulDivD = 1'b1; MfHiLoD = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, Hi}, 64'd0);
        check("rst_lo", {32'd0, Lo}, 64'd0);
        check("rst_ready", {63'd0, Ready}, 64'd0);
        check("rst_divzero", {63'd0, DivZero}, 64'd0);
        check("rst_stall", {63'd0, MulDivStall}, 64'd0);
        rst = 1'b0; MulDivD = 1'b0; MfHiLoD = 1'b0;
        @(posedge clk);
        #1;

        run_op(OP_MULT,  32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_7_m3");
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h40000000, 32'h00000000, 1'b0, "mult_min_sq");
        run_op(OP_MULT,  32'hFFFFFFFF, 32'd5,        1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, "mult_m1_5_poke");
        run_op(OP_MULTU, 32'h12345678, 32'h10,       1'b0, 1'b0, 32'h00000001, 32'h23456780, 1'b0, "multu_shift");

`ifdef MULDIV_DIV_EN
        run_op(OP_DIVU, 32'd100,      32'd7,        1'b0, 1'b0, 32'd2,        32'd14,       1'b0, "divu_100_7");
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        run_op(OP_DIV,  32'd5,        32'd0,        1'b1, 1'b0, 32'd5,        32'hFFFFFFFF, 1'b1, "div_5_0");
        run_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 1'b0, 1'b1, 32'd1,        32'hFFFFFFFD, 1'b0, "div_7_m2_poke");
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0,        32'hFFFFFFFF, 1'b0, "divu_max_1");
        run_op(OP_DIV,  32'hFFFFFFFB, 32'd0,        1'b0, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_m5_0");
`else
        StartE = 1'b1; OpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; MulDivD = 1'b1; MfHiLoD = 1'b1;
        #1;
        check("nodiv_stall_at_start", {63'd0, MulDivStall}, 64'd0);
        rdy_n = 0;
        stl_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                StartE = 1'b0; MulDivD = 1'b0;
            end
            #1;
            if (Ready) rdy_n++;
            if (MulDivStall) stl_n++;
        end
        check("nodiv_ready_count", rdy_n, 0);
        check("nodiv_stall_count", stl_n, 0);
        check("nodiv_hi", {32'd0, Hi}, 64'h1);
        check("nodiv_lo", {32'd0, Lo}, 64'h23456780);
`endif

        // Reset in the middle of a MULTU (counter at 10).
        StartE = 1'b1; OpE = OP_MULTU; SrcAE = 32'd1234; SrcBE = 32'd5678; MulDivD = 1'b0; MfHiLoD = 1'b0;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        MfHiLoD = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_hi", {32'd0, Hi}, 64'd0);
        check("midrst_lo", {32'd0, Lo}, 64'd0);
        check("midrst_ready", {63'd0, Ready}, 64'd0);
        check("midrst_stall", {63'd0, MulDivStall}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Ready) rdy_n++;
        end
        check("midrst_no_ready", rdy_n, 0);
        check("midrst_hi_held", {32'd0, Hi}, 64'd0);
        MfHiLoD = 1'b0;

        run_op(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd15, 1'b0, "multu_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL provide: clk  in  1  single pipeline clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: StartE  in  1  MULT/MULTU/DIV/DIVU valid in execute stage this cycle.
REQ-004 SHALL provide: OpE  in  2  operation; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL provide: SrcAE  in  32  rs operand (multiplicand/dividend).
REQ-006 SHALL provide: SrcBE  in  32  rt operand (multiplier/divisor).
REQ-007 SHALL provide: MulDivD  in  1  mult/div instruction in decode.
REQ-008 SHALL provide: MfHiLoD  in  1  MFHI/MFLO in decode.
REQ-009 SHALL provide: MulDivStall  out  1  to hazard unit, ORed into StallF/StallD/FlushE.
REQ-010 SHALL provide: Hi  out  32  HI register; Lo  out  32  LO register.
REQ-011 SHALL provide: Ready  out  1  one-cycle pulse when HI/LO updated.
REQ-012 SHALL provide: DivZero  out  1  one-cycle pulse with Ready when divisor was 0.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; IDLE->MUL on StartE with OpE[1]=0, IDLE->DIV on StartE with OpE[1]=1.
REQ-014 SHALL run exactly 32 iterations (5-bit counter, 0..31) in MUL/DIV, returning to IDLE on the edge ending iteration 31.
REQ-015 SHALL write Hi/Lo on that same edge and assert Ready (and DivZero if applicable) for the following cycle only.
REQ-016 SHALL compute MUL as unsigned shift-add on magnitudes; signed MULT negates the 64-bit result when SrcAE[31]^SrcBE[31]; Hi=product[63:32], Lo=product[31:0].
REQ-017 SHALL compute DIV as restoring division on magnitudes; Lo=quotient, Hi=remainder; signed quotient sign = sA^sB, remainder sign = sA.
REQ-018 SHALL, on divisor 0, still take 32 cycles, then set Hi=dividend (unmodified SrcAE), Lo=32'hFFFFFFFF, pulse DivZero.
REQ-019 SHALL latch operands, op and sign flags at start; SrcAE/SrcBE changes during operation SHALL NOT affect the result.
REQ-020 SHALL define busy = (state != IDLE) || StartE.
REQ-021 SHALL drive MulDivStall = busy && (MfHiLoD || MulDivD), combinational.
REQ-022 SHALL ignore StartE while state != IDLE (cannot occur under REQ-021); Hi/Lo unchanged by ignored start.
REQ-023 SHALL hold Hi/Lo stable except on the completion edge.
REQ-024 SHALL allow StartE in the cycle Ready is high (back-to-back operations, no bubble).

Reset
REQ-025 SHALL on rst, at any time including mid-operation: state=IDLE, counter=0, Hi=0, Lo=0, Ready=0, DivZero=0, MulDivStall=0 (given StartE=0); partial results discarded.

Configuration
REQ-026 SHALL compile divide support only when macro MULDIV_DIV_EN is defined.
REQ-027 SHALL without MULDIV_DIV_EN: no DIV state, StartE with OpE[1]=1 ignored (no busy, no stall, no Ready), DivZero tied 0.

Structure
REQ-028 SHALL place OpE encodings, FSM state enum and MULDIV_ITER=32 in shared package muldiv_pkg.
REQ-029 SHALL isolate the per-iteration shift-add/restoring step datapath in one sub-module muldiv_step; FSM, counter, sign fix-up and HI/LO in muldiv_seq.

Verification
REQ-030 SHALL test MULT 7 x 32'hFFFFFFFD -> after 32 busy cycles Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB, Ready one cycle.
REQ-031 SHALL test DIVU 100/7 -> Lo=14, Hi=2; DIV -7/2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
REQ-032 SHALL test DIV 5/0 -> Hi=5, Lo=32'hFFFFFFFF, DivZero and Ready pulse together.
REQ-033 SHALL test StartE with MfHiLoD high same cycle -> MulDivStall high 33 consecutive cycles, low in Ready cycle.
REQ-034 SHALL test rst asserted at iteration 10 of MULTU -> immediately IDLE, Hi=Lo=0, no Ready afterwards.
REQ-035 SHALL test build without MULDIV_DIV_EN: DIVU 100/7 -> no stall, no Ready, Hi/Lo unchanged.
